wide_uart_arbiter: RTL

Shares one `wide_uart` link between two 64-bit AXI-Stream requesters. It round-robin arbitrates requester words onto the UART transmit stream and records which requester issued each word in a tag FIFO. Each word returned on the UART receive stream is steered back to the requester whose tag is at the FIFO head. The block sits directly in front of `wide_uart`: its `u_tx_*` port drives `wide_uart.s_axis_*`, and its `u_rx_*` port takes `wide_uart.m_axis_*`.

---
 rtl/wide_uart_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wide_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wide_uart_arbiter
// Description : Round-robin sharing of one wide_uart link between two AXIS
//               requesters. A tag FIFO remembers who issued each word so the
//               returning responses can be steered back to their owners.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_uart_arbiter #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          s0_tdata,
    input  logic                       s0_tvalid,
    output logic                       s0_tready,
    input  logic [DATA_W-1:0]          s1_tdata,
    input  logic                       s1_tvalid,
    output logic                       s1_tready,
    output logic [DATA_W-1:0]          r0_tdata,
    output logic                       r0_tvalid,
    input  logic                       r0_tready,
    output logic [DATA_W-1:0]          r1_tdata,
    output logic                       r1_tvalid,
    input  logic                       r1_tready,
    output logic [DATA_W-1:0]          u_tx_tdata,
    output logic                       u_tx_tvalid,
    input  logic                       u_tx_tready,
    input  logic [DATA_W-1:0]          u_rx_tdata,
    input  logic                       u_rx_tvalid,
    output logic                       u_rx_tready,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       orphan_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_grant;
    logic               w_grant_nxt;
    logic               r_last_grant;
    logic [DEPTH-1:0]   r_tag_mem;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_orphan;

    logic               w_sel_valid;
    logic               w_space;
    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;
    logic               w_head;

    assign w_sel_valid = r_grant ? s1_tvalid : s0_tvalid;
    assign w_space     = (r_count < c_depth);
    assign w_nonempty  = (r_count != '0);
    assign w_head      = r_tag_mem[r_rd_ptr];

    // Arbitration FSM: next state, grant selection and transmit-side muxing
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_push      = 1'b0;
        u_tx_tdata  = r_grant ? s1_tdata : s0_tdata;
        u_tx_tvalid = 1'b0;
        s0_tready   = 1'b0;
        s1_tready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((s0_tvalid || s1_tvalid) && w_space) begin
                    w_state_nxt = S_SEND;
                    if (s0_tvalid && s1_tvalid)
                        w_grant_nxt = ~r_last_grant;
                    else
                        w_grant_nxt = s1_tvalid;
                end
            end
            S_SEND: begin
                u_tx_tvalid = w_sel_valid;
                s0_tready   = ~r_grant & u_tx_tready;
                s1_tready   =  r_grant & u_tx_tready;
                // A requester withdrawing its word abandons the grant unpushed
                if (!w_sel_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (u_tx_tready) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Response steering by the tag at the FIFO head; orphans are sunk
    assign r0_tdata    = u_rx_tdata;
    assign r1_tdata    = u_rx_tdata;
    assign r0_tvalid   = w_nonempty & ~w_head & u_rx_tvalid;
    assign r1_tvalid   = w_nonempty &  w_head & u_rx_tvalid;
    assign u_rx_tready = w_nonempty ? (w_head ? r1_tready : r0_tready) : 1'b1;
    assign w_pop       = w_nonempty & u_rx_tvalid & u_rx_tready;

    assign outstanding = r_count;
    assign orphan_err  = r_orphan;

    // FSM state, current grant and round-robin history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_push)
                r_last_grant <= r_grant;
        end
    end

    // Tag FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_mem <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr] <= r_grant;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for responses arriving with nothing outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_orphan <= 1'b0;
        else if (!w_nonempty && u_rx_tvalid)
            r_orphan <= 1'b1;
    end

endmodule
`default_nettype wire
